// File: rtl/calc_pkg.sv
// Shared number format and seven-segment helpers for the calculator display path.
// Pure types, constants and combinational functions; no latency, no flow control.
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int DigitIdxW = $clog2(NumDigits);

  typedef logic [3:0] bcd_t;

  // exponent counts fractional digits; significand[0] is the rightmost digit
  typedef struct packed {
    logic                 error;
    logic                 sign;
    logic [DigitIdxW-1:0] exponent;
    bcd_t [NumDigits-1:0] significand;
  } num_t;

  localparam logic [6:0] SegOff    = 7'b0000000;
  localparam logic [6:0] SegLetterE = 7'b1001111;

  // Segments a..g on bits 6..0, active-high; non-decimal codes stay dark.
  function automatic logic [6:0] bcd2segments(input bcd_t digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = SegOff;
    endcase
    return seg;
  endfunction

  // A digit is a leading zero when it sits left of the decimal point and
  // nothing at or above it is non-zero.
  function automatic logic digit_blanked(input num_t num, input logic [DigitIdxW-1:0] idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NumDigits; j++) begin
      if ((j >= int'(idx)) && (num.significand[j] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    return (idx > num.exponent) && upper_zero;
  endfunction

endpackage

// File: rtl/display_digit_decode.sv
// Maps one digit position of a number to its segment pattern and decimal point.
// Combinational, zero latency; no flow control.
module display_digit_decode
  import calc_pkg::*;
(
  input  logic [DigitIdxW-1:0] digit_idx,
  input  num_t                 num,
  output logic [6:0]           segments,
  output logic                 dp
);

  always_comb begin
    segments = SegOff;
    dp       = 1'b0;
    if (num.error) begin
      // error shows a lone E on the rightmost digit
      if (digit_idx == '0) begin
        segments = SegLetterE;
      end
    end else begin
      if (!digit_blanked(num, digit_idx)) begin
        segments = bcd2segments(num.significand[digit_idx]);
      end
      dp = (digit_idx == num.exponent) && (num.exponent != '0);
    end
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed seven-segment scanner: frame-synchronous value load, guard gap per digit.
// Outputs registered, one cycle behind scan state; num_valid_i is always accepted (last value wins).
module display_scan
  import calc_pkg::*;
#(
  parameter int DwellCycles = 1000,
  parameter int GuardCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  num_t                 num_i,
  input  logic                 num_valid_i,
  input  logic                 blank_i,
  output logic [6:0]           segments_o,
  output logic                 dp_o,
  output logic [NumDigits-1:0] digit_sel_o,
  output logic                 sign_o,
  output logic                 error_o
);

  localparam int CntW = (DwellCycles > 1) ? $clog2(DwellCycles) : 1;
  localparam logic [CntW-1:0]      DwellLast = CntW'(DwellCycles - 1);
  localparam logic [CntW-1:0]      GuardLast = CntW'((GuardCycles > 0) ? GuardCycles - 1 : 0);
  localparam logic [DigitIdxW-1:0] IdxLast   = DigitIdxW'(NumDigits - 1);

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CntW-1:0]      dwell_cnt_q, dwell_cnt_d;
  logic [DigitIdxW-1:0] digit_idx_q, digit_idx_d;
  logic                 dwell_end;
  logic                 frame_end;

  num_t                 display_q;
  num_t                 pending_q;
  logic                 pending_vld_q;

  logic [6:0]           dec_segments;
  logic                 dec_dp;
  logic                 drive_on;

  always_comb begin
    state_d     = state_q;
    dwell_cnt_d = dwell_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    dwell_end   = 1'b0;
    case (state_q)
      GUARD: begin
        // with no guard time the post-reset GUARD cycle is a pass-through
        if (GuardCycles == 0) begin
          state_d     = DRIVE;
          dwell_cnt_d = dwell_cnt_q;
        end else if (dwell_cnt_q == GuardLast) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (dwell_cnt_q == DwellLast) begin
          dwell_end   = 1'b1;
          dwell_cnt_d = '0;
          digit_idx_d = (digit_idx_q == IdxLast) ? '0 : digit_idx_q + 1'b1;
          state_d     = (GuardCycles == 0) ? DRIVE : GUARD;
        end
      end
      default: begin
        state_d = GUARD;
      end
    endcase
  end

  assign frame_end = dwell_end && (digit_idx_q == IdxLast);

  display_digit_decode u_decode (
    .digit_idx (digit_idx_q),
    .num       (display_q),
    .segments  (dec_segments),
    .dp        (dec_dp)
  );

  assign drive_on = (state_q == DRIVE) && !blank_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= GUARD;
      dwell_cnt_q   <= '0;
      digit_idx_q   <= '0;
      display_q     <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      segments_o    <= '0;
      dp_o          <= 1'b0;
      digit_sel_o   <= '0;
      sign_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_cnt_q <= dwell_cnt_d;
      digit_idx_q <= digit_idx_d;

      if (num_valid_i) begin
        pending_q <= num_i;
      end
      // a strobe on the boundary cycle bypasses the pending register
      if (frame_end) begin
        if (num_valid_i) begin
          display_q <= num_i;
        end else if (pending_vld_q) begin
          display_q <= pending_q;
        end
        pending_vld_q <= 1'b0;
      end else if (num_valid_i) begin
        pending_vld_q <= 1'b1;
      end

      digit_sel_o <= drive_on ? ({{(NumDigits-1){1'b0}}, 1'b1} << digit_idx_q) : '0;
      segments_o  <= drive_on ? dec_segments : SegOff;
      dp_o        <= drive_on && dec_dp;
      sign_o      <= display_q.sign && !display_q.error && !blank_i;
      error_o     <= display_q.error && !blank_i;
    end
  end

endmodule
